// File: rtl/axil_s_regs.sv
// AXI4-Lite register-bank slave with 32-bit registers, byte-lane writes and a per-write strobe.
// Read and write channels are independent, each with at most one transaction in flight.
module axil_s_regs #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned NUM_REGS   = 16
) (
    input  logic                            aclk,
    input  logic                            aresetn,
    input  logic [ADDR_WIDTH-1:0]           s_axi_awaddr,
    input  logic [2:0]                      s_axi_awprot,
    input  logic                            s_axi_awvalid,
    output logic                            s_axi_awready,
    input  logic [31:0]                     s_axi_wdata,
    input  logic [3:0]                      s_axi_wstrb,
    input  logic                            s_axi_wvalid,
    output logic                            s_axi_wready,
    output logic [1:0]                      s_axi_bresp,
    output logic                            s_axi_bvalid,
    input  logic                            s_axi_bready,
    input  logic [ADDR_WIDTH-1:0]           s_axi_araddr,
    input  logic [2:0]                      s_axi_arprot,
    input  logic                            s_axi_arvalid,
    output logic                            s_axi_arready,
    output logic [31:0]                     s_axi_rdata,
    output logic [1:0]                      s_axi_rresp,
    output logic                            s_axi_rvalid,
    input  logic                            s_axi_rready,
    output logic [NUM_REGS*32-1:0]          reg_q,
    output logic                            wr_pulse,
    output logic [$clog2(NUM_REGS)-1:0]     wr_idx
);

    localparam int unsigned IDX_W  = $clog2(NUM_REGS);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = 4;
    localparam int unsigned LIM_W  = ADDR_WIDTH + 1;
    localparam logic [LIM_W-1:0] ADDR_LIMIT = LIM_W'(NUM_REGS * 4);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {R_IDLE, R_DATA} rstate_e;

    // Full-width compare so aliased high addresses are rejected.
    function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
        return {1'b0, a} < ADDR_LIMIT;
    endfunction

    logic [DATA_W-1:0] regs_q [NUM_REGS];

    // Write channel state
    logic                  aw_held_q, aw_held_d;
    logic                  w_held_q,  w_held_d;
    logic [ADDR_WIDTH-1:0] awaddr_q,  awaddr_d;
    logic [DATA_W-1:0]     wdata_q,   wdata_d;
    logic [STRB_W-1:0]     wstrb_q,   wstrb_d;
    logic                  awready_q, awready_d;
    logic                  wready_q,  wready_d;
    logic                  bvalid_q,  bvalid_d;
    logic [1:0]            bresp_q,   bresp_d;
    logic                  wr_pulse_q;
    logic [IDX_W-1:0]      wr_idx_q;

    // Read channel state
    rstate_e               rstate_q;
    logic                  arready_q;
    logic                  rvalid_q;
    logic [DATA_W-1:0]     rdata_q;
    logic [1:0]            rresp_q;

    logic                  aw_hs_c, w_hs_c, commit_c, cm_ok_c;
    logic [ADDR_WIDTH-1:0] cm_addr_c;
    logic [DATA_W-1:0]     cm_data_c;
    logic [STRB_W-1:0]     cm_strb_c;
    logic [IDX_W-1:0]      cm_idx_c;
    logic                  ar_hs_c, ar_ok_c;
    logic [IDX_W-1:0]      ar_idx_c;
    logic                  unused_c;

    assign unused_c = ^{s_axi_awprot, s_axi_arprot};

    // Write-path next state: commit once both halves are present, hold B until bready.
    always_comb begin
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;

        aw_hs_c   = s_axi_awvalid && awready_q;
        w_hs_c    = s_axi_wvalid  && wready_q;
        cm_addr_c = aw_held_q ? awaddr_q : s_axi_awaddr;
        cm_data_c = w_held_q  ? wdata_q  : s_axi_wdata;
        cm_strb_c = w_held_q  ? wstrb_q  : s_axi_wstrb;
        cm_idx_c  = cm_addr_c[2 +: IDX_W];
        cm_ok_c   = addr_ok(cm_addr_c);
        commit_c  = (aw_held_q || aw_hs_c) && (w_held_q || w_hs_c) && !bvalid_q;

        if (aw_hs_c) begin
            aw_held_d = 1'b1;
            awaddr_d  = s_axi_awaddr;
        end
        if (w_hs_c) begin
            w_held_d = 1'b1;
            wdata_d  = s_axi_wdata;
            wstrb_d  = s_axi_wstrb;
        end
        if (commit_c) begin
            bvalid_d = 1'b1;
            bresp_d  = cm_ok_c ? RESP_OKAY : RESP_SLVERR;
        end
        if (bvalid_q && s_axi_bready) begin
            bvalid_d  = 1'b0;
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
        end

        awready_d = !aw_held_d && !bvalid_d;
        wready_d  = !w_held_d  && !bvalid_d;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
        end
    end

    // Register array with per-byte-lane update on an in-range commit.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs_q[i] <= '0;
            end
            wr_pulse_q <= 1'b0;
            wr_idx_q   <= '0;
        end else begin
            wr_pulse_q <= commit_c && cm_ok_c;
            if (commit_c && cm_ok_c) begin
                wr_idx_q <= cm_idx_c;
                for (int k = 0; k < int'(STRB_W); k++) begin
                    if (cm_strb_c[k]) begin
                        regs_q[cm_idx_c][8*k +: 8] <= cm_data_c[8*k +: 8];
                    end
                end
            end
        end
    end

    assign ar_hs_c  = s_axi_arvalid && arready_q;
    assign ar_idx_c = s_axi_araddr[2 +: IDX_W];
    assign ar_ok_c  = addr_ok(s_axi_araddr);

    // Read FSM; samples the array before any same-cycle write lands.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rstate_q  <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            case (rstate_q)
                R_IDLE: begin
                    arready_q <= 1'b1;
                    if (ar_hs_c) begin
                        rdata_q   <= ar_ok_c ? regs_q[ar_idx_c] : '0;
                        rresp_q   <= ar_ok_c ? RESP_OKAY : RESP_SLVERR;
                        rvalid_q  <= 1'b1;
                        arready_q <= 1'b0;
                        rstate_q  <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (s_axi_rready) begin
                        rvalid_q  <= 1'b0;
                        arready_q <= 1'b1;
                        rstate_q  <= R_IDLE;
                    end
                end
                default: begin
                    rvalid_q  <= 1'b0;
                    arready_q <= 1'b0;
                    rstate_q  <= R_IDLE;
                end
            endcase
        end
    end

    for (genvar g = 0; g < int'(NUM_REGS); g++) begin : g_flat
        assign reg_q[32*g +: 32] = regs_q[g];
    end

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = wready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;
    assign wr_pulse      = wr_pulse_q;
    assign wr_idx        = wr_idx_q;

endmodule

// File: tb/tb_axil_s_regs.sv
// Directed bench for axil_s_regs: hand-computed responses, register contents and timing.
module tb_axil_s_regs;

    localparam int unsigned ADDR_WIDTH = 32;
    localparam int unsigned NUM_REGS   = 16;

    logic                        aclk = 1'b0;
    logic                        aresetn;
    logic [ADDR_WIDTH-1:0]       s_axi_awaddr;
    logic [2:0]                  s_axi_awprot;
    logic                        s_axi_awvalid;
    logic                        s_axi_awready;
    logic [31:0]                 s_axi_wdata;
    logic [3:0]                  s_axi_wstrb;
    logic                        s_axi_wvalid;
    logic                        s_axi_wready;
    logic [1:0]                  s_axi_bresp;
    logic                        s_axi_bvalid;
    logic                        s_axi_bready;
    logic [ADDR_WIDTH-1:0]       s_axi_araddr;
    logic [2:0]                  s_axi_arprot;
    logic                        s_axi_arvalid;
    logic                        s_axi_arready;
    logic [31:0]                 s_axi_rdata;
    logic [1:0]                  s_axi_rresp;
    logic                        s_axi_rvalid;
    logic                        s_axi_rready;
    logic [NUM_REGS*32-1:0]      reg_q;
    logic                        wr_pulse;
    logic [$clog2(NUM_REGS)-1:0] wr_idx;

    int errors = 0;
    int checks = 0;

    axil_s_regs #(.ADDR_WIDTH(ADDR_WIDTH), .NUM_REGS(NUM_REGS)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .reg_q(reg_q), .wr_pulse(wr_pulse), .wr_idx(wr_idx)
    );

    always #5 aclk = ~aclk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // Write with AW and W together; bready raised the cycle bvalid appears.
    task automatic axi_write(input string tag, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, input logic [1:0] exp_resp,
                             input logic exp_pulse, input logic [3:0] exp_idx);
        check_eq({tag, ".awready"}, 32'(s_axi_awready), 32'd1);
        check_eq({tag, ".wready"},  32'(s_axi_wready),  32'd1);
        s_axi_awaddr = a; s_axi_wdata = d; s_axi_wstrb = s;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
        tick();
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        check_eq({tag, ".bvalid"},   32'(s_axi_bvalid), 32'd1);
        check_eq({tag, ".bresp"},    32'(s_axi_bresp),  32'(exp_resp));
        check_eq({tag, ".wr_pulse"}, 32'(wr_pulse),     32'(exp_pulse));
        if (exp_pulse) check_eq({tag, ".wr_idx"}, 32'(wr_idx), 32'(exp_idx));
        s_axi_bready = 1'b1;
        tick();
        s_axi_bready = 1'b0;
        check_eq({tag, ".bvalid_drop"}, 32'(s_axi_bvalid),  32'd0);
        check_eq({tag, ".awready_ret"}, 32'(s_axi_awready), 32'd1);
        check_eq({tag, ".wready_ret"},  32'(s_axi_wready),  32'd1);
    endtask

    task automatic axi_read(input string tag, input logic [31:0] a,
                            input logic [31:0] exp_data, input logic [1:0] exp_resp);
        check_eq({tag, ".arready"}, 32'(s_axi_arready), 32'd1);
        s_axi_araddr = a; s_axi_arvalid = 1'b1;
        tick();
        s_axi_arvalid = 1'b0;
        check_eq({tag, ".rvalid"}, 32'(s_axi_rvalid), 32'd1);
        check_eq({tag, ".rdata"},  s_axi_rdata,       exp_data);
        check_eq({tag, ".rresp"},  32'(s_axi_rresp),  32'(exp_resp));
        s_axi_rready = 1'b1;
        tick();
        s_axi_rready = 1'b0;
        check_eq({tag, ".rvalid_drop"}, 32'(s_axi_rvalid),  32'd0);
        check_eq({tag, ".arready_ret"}, 32'(s_axi_arready), 32'd1);
    endtask

    initial begin
        aresetn = 1'b0;
        s_axi_awaddr = '0; s_axi_awprot = '0; s_axi_awvalid = 1'b0;
        s_axi_wdata = '0;  s_axi_wstrb = '0;  s_axi_wvalid = 1'b0;
        s_axi_bready = 1'b0;
        s_axi_araddr = '0; s_axi_arprot = '0; s_axi_arvalid = 1'b0;
        s_axi_rready = 1'b0;

        // Reset state
        repeat (3) tick();
        check_eq("rst.awready",  32'(s_axi_awready), 32'd0);
        check_eq("rst.wready",   32'(s_axi_wready),  32'd0);
        check_eq("rst.arready",  32'(s_axi_arready), 32'd0);
        check_eq("rst.bvalid",   32'(s_axi_bvalid),  32'd0);
        check_eq("rst.rvalid",   32'(s_axi_rvalid),  32'd0);
        check_eq("rst.rdata",    s_axi_rdata,        32'd0);
        check_eq("rst.wr_pulse", 32'(wr_pulse),      32'd0);
        check_eq("rst.wr_idx",   32'(wr_idx),        32'd0);
        check_eq("rst.reg2",     reg_q[64 +: 32],    32'd0);
        aresetn = 1'b1;
        tick();
        check_eq("rel.awready", 32'(s_axi_awready), 32'd1);
        check_eq("rel.wready",  32'(s_axi_wready),  32'd1);
        check_eq("rel.arready", 32'(s_axi_arready), 32'd1);

        // Full-word write and readback
        axi_write("w08", 32'h0000_0008, 32'h5AA5_A55A, 4'hF, 2'b00, 1'b1, 4'd2);
        check_eq("w08.reg_q", reg_q[95:64], 32'h5AA5_A55A);
        axi_read("r08", 32'h0000_0008, 32'h5AA5_A55A, 2'b00);

        // Partial strobe: only the low two bytes change
        axi_write("w08p", 32'h0000_0008, 32'h1234_5678, 4'b0011, 2'b00, 1'b1, 4'd2);
        axi_read("r08p", 32'h0000_0008, 32'h5AA5_5678, 2'b00);

        // W two cycles ahead of AW
        s_axi_wdata = 32'hCAFE_0001; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
        tick();
        s_axi_wvalid = 1'b0;
        check_eq("split.wready_lo",  32'(s_axi_wready),  32'd0);
        check_eq("split.awready_hi", 32'(s_axi_awready), 32'd1);
        check_eq("split.bvalid_lo",  32'(s_axi_bvalid),  32'd0);
        tick();
        check_eq("split.bvalid_lo2", 32'(s_axi_bvalid),  32'd0);
        s_axi_awaddr = 32'h0000_000C; s_axi_awvalid = 1'b1;
        tick();
        s_axi_awvalid = 1'b0;
        check_eq("split.bvalid",   32'(s_axi_bvalid), 32'd1);
        check_eq("split.bresp",    32'(s_axi_bresp),  32'd0);
        check_eq("split.wr_pulse", 32'(wr_pulse),     32'd1);
        check_eq("split.wr_idx",   32'(wr_idx),       32'd3);
        check_eq("split.reg3",     reg_q[96 +: 32],   32'hCAFE_0001);
        s_axi_bready = 1'b1;
        tick();
        s_axi_bready = 1'b0;
        check_eq("split.bvalid_drop", 32'(s_axi_bvalid),  32'd0);
        check_eq("split.awready_ret", 32'(s_axi_awready), 32'd1);
        check_eq("split.wready_ret",  32'(s_axi_wready),  32'd1);

        // Out-of-range write and read (index bits alias to reg 14)
        axi_write("woor", 32'hAAAA_BBBB, 32'h1111_1111, 4'hF, 2'b10, 1'b0, 4'd0);
        check_eq("woor.wr_pulse", 32'(wr_pulse),    32'd0);
        check_eq("woor.reg14",    reg_q[448 +: 32], 32'd0);
        check_eq("woor.reg2",     reg_q[64 +: 32],  32'h5AA5_5678);
        axi_read("roor", 32'hAAAA_BBBB, 32'd0, 2'b10);

        // B back-pressure
        s_axi_awaddr = 32'h0000_0010; s_axi_wdata = 32'h0BAD_F00D; s_axi_wstrb = 4'hF;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
        tick();
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check_eq("bp.bvalid",  32'(s_axi_bvalid),  32'd1);
            check_eq("bp.bresp",   32'(s_axi_bresp),   32'd0);
            check_eq("bp.awready", 32'(s_axi_awready), 32'd0);
            check_eq("bp.wready",  32'(s_axi_wready),  32'd0);
            tick();
        end
        s_axi_bready = 1'b1;
        tick();
        s_axi_bready = 1'b0;
        check_eq("bp.bvalid_drop", 32'(s_axi_bvalid),  32'd0);
        check_eq("bp.awready_ret", 32'(s_axi_awready), 32'd1);
        check_eq("bp.wready_ret",  32'(s_axi_wready),  32'd1);

        // R back-pressure
        s_axi_araddr = 32'h0000_0010; s_axi_arvalid = 1'b1;
        tick();
        s_axi_arvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check_eq("rp.rvalid",  32'(s_axi_rvalid),  32'd1);
            check_eq("rp.rdata",   s_axi_rdata,        32'h0BAD_F00D);
            check_eq("rp.rresp",   32'(s_axi_rresp),   32'd0);
            check_eq("rp.arready", 32'(s_axi_arready), 32'd0);
            tick();
        end
        s_axi_rready = 1'b1;
        tick();
        s_axi_rready = 1'b0;
        check_eq("rp.rvalid_drop", 32'(s_axi_rvalid),  32'd0);
        check_eq("rp.arready_ret", 32'(s_axi_arready), 32'd1);

        // Same-cycle read and write of 0x04: read sees the old value
        s_axi_awaddr = 32'h0000_0004; s_axi_wdata = 32'hDEAD_BEEF; s_axi_wstrb = 4'hF;
        s_axi_araddr = 32'h0000_0004;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_arvalid = 1'b1;
        tick();
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
        check_eq("rw.rvalid", 32'(s_axi_rvalid), 32'd1);
        check_eq("rw.rdata",  s_axi_rdata,       32'd0);
        check_eq("rw.bvalid", 32'(s_axi_bvalid), 32'd1);
        check_eq("rw.wr_idx", 32'(wr_idx),       32'd1);
        s_axi_bready = 1'b1; s_axi_rready = 1'b1;
        tick();
        s_axi_bready = 1'b0; s_axi_rready = 1'b0;
        axi_read("rw.after", 32'h0000_0004, 32'hDEAD_BEEF, 2'b00);

        // Reset while a B response is pending
        s_axi_awaddr = 32'h0000_0018; s_axi_wdata = 32'h0000_0077; s_axi_wstrb = 4'hF;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
        tick();
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        check_eq("mrst.bvalid_pre", 32'(s_axi_bvalid), 32'd1);
        #2;
        aresetn = 1'b0;
        #1;
        check_eq("mrst.bvalid",   32'(s_axi_bvalid),  32'd0);
        check_eq("mrst.wr_pulse", 32'(wr_pulse),      32'd0);
        check_eq("mrst.awready",  32'(s_axi_awready), 32'd0);
        check_eq("mrst.arready",  32'(s_axi_arready), 32'd0);
        check_eq("mrst.reg1",     reg_q[32 +: 32],    32'd0);
        check_eq("mrst.reg2",     reg_q[64 +: 32],    32'd0);
        check_eq("mrst.reg6",     reg_q[192 +: 32],   32'd0);
        tick();
        aresetn = 1'b1;
        tick();
        check_eq("mrst.awready_rel", 32'(s_axi_awready), 32'd1);
        check_eq("mrst.wready_rel",  32'(s_axi_wready),  32'd1);
        check_eq("mrst.arready_rel", 32'(s_axi_arready), 32'd1);
        check_eq("mrst.bvalid_rel",  32'(s_axi_bvalid),  32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axil_s_regs.md
# axil_s_regs

AXI4-Lite slave (responder) with a memory-mapped register bank, the counterpart to the `axis_lite_m` master. It sits on the same `axil_itf` bus in place of the VIP slave and exposes its registers to user logic. It also raises a per-write notification strobe. Read and write channels are independent and each carries one outstanding transaction.

## Interface
- `ADDR_WIDTH`, 32, AXI address width.
- `NUM_REGS`, 16, number of 32-bit registers; power of two, 2..256.
- Data width is fixed at 32 bits; `wstrb` is 4 bits.

- `aclk` in 1, single clock; all logic on the rising edge.
- `aresetn` in 1, asynchronous active-low reset.
- `s_axi_awaddr` in ADDR_WIDTH, write address.
- `s_axi_awprot` in 3, ignored.
- `s_axi_awvalid` in 1 / `s_axi_awready` out 1, AW handshake.
- `s_axi_wdata` in 32, write data.
- `s_axi_wstrb` in 4, byte enables.
- `s_axi_wvalid` in 1 / `s_axi_wready` out 1, W handshake.
- `s_axi_bresp` out 2 / `s_axi_bvalid` out 1 / `s_axi_bready` in 1, write response.
- `s_axi_araddr` in ADDR_WIDTH, read address.
- `s_axi_arprot` in 3, ignored.
- `s_axi_arvalid` in 1 / `s_axi_arready` out 1, AR handshake.
- `s_axi_rdata` out 32 / `s_axi_rresp` out 2 / `s_axi_rvalid` out 1 / `s_axi_rready` in 1, read data.
- `reg_q` out NUM_REGS*32, flat register contents; register i is at bits [32*i +: 32].
- `wr_pulse` out 1, one-cycle strobe after every in-range write commit.
- `wr_idx` out clog2(NUM_REGS), index of the register written; valid while `wr_pulse` is high.

## Operation
- **Address decode.**
  - Register index = `addr[2 +: clog2(NUM_REGS)]`. `addr[1:0]` is ignored.
  - An address is in range iff the full-width `addr < NUM_REGS*4`.
  - Out-of-range writes are discarded and return SLVERR (2'b10). Out-of-range reads return `rdata` 0 with SLVERR.
  - In-range accesses return OKAY (2'b00).
- **Write path.** Two flags, `aw_held` and `w_held`, plus latched address/data/strobe.
  - AW and W are accepted independently, in either order or in the same cycle.
  - `awready` is high iff no address is held and no B response is pending. `wready` follows the same rule for data.
  - Commit happens in the cycle both are held (or both handshake). Each byte lane k with `wstrb[k]`=1 updates the register; other lanes keep their value.
  - `bvalid` rises the next cycle and is held with a stable `bresp` until `bready`.
  - On the B handshake both flags clear, and `awready`/`wready` return high the following cycle.
- **Read path.** States R_IDLE → R_DATA.
  - In R_IDLE, `arready` is 1. An AR handshake registers `rdata`/`rresp` from the current register contents and moves to R_DATA.
  - In R_DATA, `arready` is 0 and `rvalid` is 1, with `rdata`/`rresp` stable. On `rready` the FSM returns to R_IDLE.
- **Same-cycle write and read** of the same register: the read returns the pre-write value.
- **`wr_pulse`/`wr_idx`.** Registered. High in the cycle after an in-range commit, which is the same cycle `bvalid` rises. Never asserted for an out-of-range write.
- **`reg_q`** reflects the register array directly, so an update is visible the cycle after commit.

## Timing
- **Reset values** (async on `aresetn`=0):
  - all registers 0;
  - `awready`, `wready`, `arready` = 0;
  - `bvalid`, `rvalid`, `wr_pulse` = 0;
  - `bresp`, `rresp`, `rdata`, `wr_idx` = 0;
  - flags cleared, read FSM in R_IDLE.
- **After release:** `awready`, `wready` and `arready` go to 1 on the first rising edge with `aresetn`=1.
- **Write latency:**
  - AW and W handshake together in cycle N: commit at the end of N, `bvalid` high in N+1.
  - If `bready` is already high, `bvalid` drops in N+2 and `awready`/`wready` are high in N+2.
  - With split AW/W, latency is measured from the later handshake.
- **Read latency:** AR handshake in cycle N gives `rvalid` in N+1. If `rready` is high, `arready` returns in N+2.
- **Back-pressure:**
  - `bvalid`, `bresp`, `rvalid`, `rdata` and `rresp` must stay constant until their handshake.
  - No new AW/W is accepted while `bvalid`=1. No new AR is accepted while `rvalid`=1.
- **Mid-transaction reset** abandons all state immediately. No response is produced for the interrupted transaction.

## Test plan
- Write `0x5AA5_A55A` to `0x08` with `wstrb` F, AW and W in the same cycle → `bvalid` one cycle later with `bresp` 0. `wr_pulse` with `wr_idx`=2. A subsequent read of `0x08` → `rdata` `0x5AA5_A55A`, `rresp` 0, `reg_q[95:64]` = `0x5AA5_A55A`.
- Then write `0x1234_5678` to `0x08` with `wstrb` 4'b0011 → read returns `0x5AA5_5678`.
- W presented 2 cycles before AW → `wready` low after the W handshake. `bvalid` rises exactly one cycle after the AW handshake. `awready`/`wready` are both 1 one cycle after the B handshake.
- Write `0x1111_1111` to `0xAAAA_BBBB` → `bresp` 2'b10, no `wr_pulse`, `reg_q` unchanged. Read `0xAAAA_BBBB` → `rdata` 0, `rresp` 2'b10.
- Hold `bready`=0 and `rready`=0 for 5 cycles → `bvalid`/`rvalid` and payloads stay stable, `awready`/`wready`/`arready` stay 0. Each releases one cycle after its ready asserts.
- Same-cycle read and write of `0x04` (old value 0, new value `0xDEAD_BEEF`) → read returns 0, and the next read returns `0xDEAD_BEEF`.
- Drop `aresetn` while `bvalid`=1 → all outputs and `reg_q` go to 0 immediately. Readies return to 1 one edge after release.
